// File: rtl/energy_dispersal.sv
`default_nettype none
// energy_dispersal: DVB transport-stream randomizer (PRBS 1+x^14+x^15, 8-packet reload groups).
// Rev 1.0
module energy_dispersal #(
  parameter int          PKT_LEN   = 188,
  parameter int          GROUP     = 8,
  parameter logic [14:0] PRBS_INIT = 15'b100101010000000,
  parameter logic [7:0]  INV_SYNC  = 8'hB8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       syn_in,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       syn_out,
  output logic       sync_err
);

  localparam logic [7:0] PKT_LEN_B  = PKT_LEN[7:0];
  localparam logic [2:0] GROUP_LAST = 3'(GROUP - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    RUN    = 2'd1,
    ORPHAN = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  byte_cnt, byte_cnt_nx;
  logic [2:0]  pkt_cnt, pkt_cnt_nx;
  logic [14:0] prbs, prbs_nx, prbs_adv;
  logic [7:0]  mask;
  logic [7:0]  dout_nx;
  logic        err_nx;

  // Eight generator steps per byte; the first bit produced lands in the mask MSB.
  always_comb begin : prbs_step
    logic [14:0] s;
    logic        fb;
    s    = prbs;
    fb   = 1'b0;
    mask = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      fb      = s[1] ^ s[0];
      mask[i] = fb;
      s       = {fb, s[14:1]};
    end
    prbs_adv = s;
  end

  always_comb begin
    state_nx    = state;
    byte_cnt_nx = byte_cnt;
    pkt_cnt_nx  = pkt_cnt;
    prbs_nx     = prbs;
    dout_nx     = din;
    err_nx      = 1'b0;
    if (din_valid) begin
      if (syn_in) begin
        byte_cnt_nx = 8'd1;
        state_nx    = RUN;
        if (state == RUN && byte_cnt < PKT_LEN_B)
          err_nx = 1'b1;
        if (pkt_cnt == 3'd0 || state == HUNT) begin
          dout_nx    = INV_SYNC;
          prbs_nx    = PRBS_INIT;
          pkt_cnt_nx = 3'd1;
        end else begin
          // Non-group sync: generator runs on, its mask is dropped.
          prbs_nx    = prbs_adv;
          pkt_cnt_nx = (pkt_cnt == GROUP_LAST) ? 3'd0 : 3'(pkt_cnt + 3'd1);
        end
      end else if (state == RUN) begin
        if (byte_cnt >= PKT_LEN_B) begin
          state_nx = ORPHAN;
          err_nx   = 1'b1;
        end else begin
          dout_nx     = din ^ mask;
          prbs_nx     = prbs_adv;
          byte_cnt_nx = 8'(byte_cnt + 8'd1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= HUNT;
      byte_cnt   <= 8'd0;
      pkt_cnt    <= 3'd0;
      prbs       <= PRBS_INIT;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      syn_out    <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      byte_cnt   <= byte_cnt_nx;
      pkt_cnt    <= pkt_cnt_nx;
      prbs       <= prbs_nx;
      dout       <= dout_nx;
      dout_valid <= din_valid;
      syn_out    <= syn_in & din_valid;
      sync_err   <= err_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_energy_dispersal.sv
`default_nettype none
// tb_energy_dispersal: directed self-checking bench for the TS randomizer.
module tb_energy_dispersal;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       syn_in = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       syn_out;
  logic       sync_err;

  int checks = 0;
  int errors = 0;
  int midx = 0;

  logic [7:0] mtab [0:1502];
  logic [7:0] pay  [0:16*188-1];
  logic [7:0] seq3 [0:2];

  energy_dispersal dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .syn_in(syn_in),
    .dout(dout), .dout_valid(dout_valid), .syn_out(syn_out), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic [7:0] d, input logic v, input logic s);
    @(negedge clk);
    din = d; din_valid = v; syn_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {20'd0, dout, dout_valid, syn_out, sync_err}, 32'd0);
  endtask

  // Sends n bytes of one packet (sync first) and checks each output against the mask table.
  task automatic run_pkt(input int base, input int n, input int grp, input bit zero,
                         input bit gaps, input bit err_sync);
    logic [7:0] d, e;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        tick(8'hA5, 1'b0, 1'b1);
        chk("gap_valid", {31'd0, dout_valid}, 32'd0);
        chk("gap_syn", {31'd0, syn_out}, 32'd0);
      end
      if (i == 0) begin
        d = 8'h47;
        if (grp == 0) begin e = 8'hB8; midx = 0; end
        else begin e = 8'h47; midx++; end
      end else begin
        d = zero ? 8'h00 : pay[(base + i) % (16*188)];
        e = d ^ mtab[midx];
        midx++;
      end
      tick(d, 1'b1, i == 0);
      chk("dout", {24'd0, dout}, {24'd0, e});
      chk("dout_valid", {31'd0, dout_valid}, 32'd1);
      chk("syn_out", {31'd0, syn_out}, {31'd0, i == 0});
      chk("sync_err", {31'd0, sync_err}, {31'd0, (i == 0) && err_sync});
      if (zero && i >= 1 && i <= 3)
        chk("mask_seq", {24'd0, dout}, {24'd0, seq3[i-1]});
    end
  endtask

  initial begin
    logic [14:0] lf;
    logic [7:0]  m;
    logic        o;

    seq3[0] = 8'h03; seq3[1] = 8'hF6; seq3[2] = 8'h08;
    lf = 15'b100101010000000;
    m  = 8'h00;
    for (int k = 0; k < 1503; k++) begin
      for (int b = 0; b < 8; b++) begin
        o  = lf[1] ^ lf[0];
        m  = {m[6:0], o};
        lf = {o, lf[14:1]};
      end
      mtab[k] = m;
    end
    for (int k = 0; k < 16*188; k++) pay[k] = 8'($urandom);

    // Reset with inputs toggling.
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(8'($urandom), c[0], ~c[0]);
      chk_zero("reset_outputs");
    end
    rst_n = 1'b0;

    // HUNT passes data through untouched.
    tick(8'h12, 1'b1, 1'b0);
    chk("hunt_pass", {24'd0, dout}, 32'h12);
    chk("hunt_err", {31'd0, sync_err}, 32'd0);

    // Zero payload exposes the mask directly.
    run_pkt(0, 188, 0, 1'b1, 1'b0, 1'b0);
    run_pkt(188, 188, 1, 1'b0, 1'b0, 1'b0);
    run_pkt(376, 188, 2, 1'b0, 1'b0, 1'b0);
    run_pkt(564, 50, 3, 1'b0, 1'b0, 1'b0);

    // Reset mid-packet, then a fresh group.
    rst_n = 1'b1;
    tick(8'h47, 1'b1, 1'b1);
    chk_zero("midpkt_reset");
    tick(8'h33, 1'b1, 1'b0);
    chk_zero("midpkt_reset2");
    rst_n = 1'b0;
    run_pkt(0, 188, 0, 1'b1, 1'b0, 1'b0);
    for (int p = 1; p < 8; p++) run_pkt(p*188, 188, p, 1'b0, 1'b0, 1'b0);

    // Sixteen back-to-back packets, two full groups.
    for (int p = 0; p < 16; p++) run_pkt(p*188, 188, p % 8, 1'b0, 1'b0, 1'b0);

    // Same first group again with an idle cycle before every byte.
    for (int p = 0; p < 8; p++) run_pkt(p*188, 188, p, 1'b0, 1'b1, 1'b0);

    // Early sync at byte 100, then a 189th byte with no sync.
    run_pkt(0, 100, 0, 1'b0, 1'b0, 1'b0);
    run_pkt(188, 188, 1, 1'b0, 1'b0, 1'b1);
    tick(8'h5A, 1'b1, 1'b0);
    chk("orphan_byte", {24'd0, dout}, 32'h5A);
    chk("orphan_err", {31'd0, sync_err}, 32'd1);
    tick(8'hC3, 1'b1, 1'b0);
    chk("orphan_pass", {24'd0, dout}, 32'hC3);
    chk("orphan_err_clr", {31'd0, sync_err}, 32'd0);
    tick(8'h00, 1'b0, 1'b0);
    chk("orphan_idle", {31'd0, dout_valid}, 32'd0);
    run_pkt(376, 20, 2, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/energy_dispersal.md
Name: energy_dispersal

Overview:
- DVB-style transport-stream randomizer. Sits at the head of the outer-coding chain: RS(204,188) encoder → convolutional interleaver.
- Takes 188-byte packets, each starting with sync byte 0x47, on a byte-wide valid-qualified stream.
- XORs payload bytes with the 1+x^14+x^15 PRBS, which reloads every 8-packet group.
- Inverts the sync byte of the first packet in each group (0x47→0xB8).

Parameters:
PKT_LEN, 188, bytes per packet including sync byte
GROUP, 8, packets per PRBS reload group
PRBS_INIT, 15'b100101010000000, generator load value; bit 14 = s1 … bit 0 = s15
INV_SYNC, 8'hB8, sync replacement for packet 0 of each group

Ports:
clk  input  1  system byte clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-high (1 = reset) despite the name
din  input  8  input byte, MSB first in bit order
din_valid  input  1  din qualifier
syn_in  input  1  marks the sync byte of a packet; ignored unless din_valid=1
dout  output  8  randomized byte
dout_valid  output  1  dout qualifier
syn_out  output  1  marks the output sync byte
sync_err  output  1  one-cycle pulse on a packet-framing error

Behaviour:
- Reset (rst_n=1 at a rising edge):
  - dout=0, dout_valid=0, syn_out=0, sync_err=0.
  - byte_cnt=0, pkt_cnt=0, PRBS register=PRBS_INIT, state=HUNT.
  - Reset mid-packet abandons that packet. The next syn_in is treated as packet 0.
- Latency: exactly 1 clk, registered. dout_valid is din_valid delayed by one cycle. syn_out is (syn_in & din_valid) delayed by one cycle.
- Accepted byte: a cycle with din_valid=1. Nothing advances when din_valid=0; gaps of any length are allowed.
- PRBS generator:
  - 15-bit shift register s1..s15.
  - Output bit = s14 xor s15; the same bit feeds back into s1 as all cells shift toward s15.
  - Eight bit-steps per advance, computed combinationally in one cycle. The first bit produced is the mask MSB.
- FSM states: HUNT, RUN, ORPHAN.
  - HUNT: bytes pass through unmodified, PRBS idle. syn_in → RUN.
  - RUN: on each accepted byte, byte_cnt++. After byte PKT_LEN-1, if the next accepted byte has no syn_in → ORPHAN, with sync_err pulsed one cycle after that byte.
  - ORPHAN: bytes pass through unmodified, PRBS frozen. syn_in → RUN.
- Sync byte (syn_in & din_valid), in any state:
  - byte_cnt←1.
  - pkt_cnt=0 or coming from HUNT: dout=INV_SYNC; PRBS←PRBS_INIT; pkt_cnt←1. The generator does not advance.
  - Otherwise: dout=din unchanged; PRBS advances 8 steps with the mask discarded; pkt_cnt←(pkt_cnt+1) mod GROUP.
  - A sync arriving early (byte_cnt<PKT_LEN in RUN) pulses sync_err, then is processed as a normal sync. pkt_cnt still advances.
- Data byte in RUN: dout = din xor mask; PRBS advances 8 steps.
- Sequence checks:
  - Mask sequence after each reload: 0x03, 0xF6, 0x08, …
  - Period = GROUP*PKT_LEN-1 = 1503 advances per group.
- Simultaneous events: syn_in with din_valid=0 has no effect. Reset dominates all other inputs.
- Widths: byte_cnt 8 bits (holds 0..188); pkt_cnt 3 bits (wraps mod GROUP).

Test Plan:
- Reset with rst_n=1 for 3 clks, inputs toggling → all outputs 0. First syn_in afterwards with din=0x47 → dout=0xB8 and syn_out=1 one clk later.
- One packet of all-zero payload after the group sync → dout stream 0xB8, 0x03, 0xF6, 0x08, … This checks the PRBS mask directly.
- 16 back-to-back packets, random payload, reference model XOR → exact match. Sync bytes of packets 1–7 and 9–15 output 0x47; packets 0 and 8 output 0xB8. sync_err stays 0.
- din_valid deasserted on every other cycle across a full group → byte-for-byte identical output to the gapless run. dout_valid mirrors din_valid with a 1-clk delay.
- syn_in at byte 100 → sync_err pulse, new packet starts. Later, 189th byte without syn_in → sync_err pulse and ORPHAN pass-through (dout=din) until the next syn_in.
- rst_n asserted at byte 50 of packet 3 → outputs 0. Next syn_in → 0xB8, and the mask restarts at 0x03.
